// File: rtl/bfx_pkg.sv
// Shared types and constants for the bfX core control path.
package bfx_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    FETCH,
    EXEC,
    RD,
    WR,
    OUT_WAIT,
    IN_WAIT,
    SCAN_F,
    SCAN_C,
    HALT
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_PTR,
    CLS_DATA,
    CLS_IO,
    CLS_BRANCH,
    CLS_STOP
  } op_class_e;

  // Opcode group field values (byte bits [3:1])
  localparam logic [2:0] GRP_PTR    = 3'b000;
  localparam logic [2:0] GRP_DATA   = 3'b001;
  localparam logic [2:0] GRP_IO     = 3'b010;
  localparam logic [2:0] GRP_BRANCH = 3'b100;

  localparam logic [7:0] STOP_BYTE = 8'hFF;

endpackage

// File: rtl/bfx_decode.sv
// Instruction byte classifier: maps an instruction byte to its class and
// direction bit (bit 0 selects >,+,out,[ versus <,-,in,]).
module bfx_decode
  import bfx_pkg::*;
(
  input  logic [7:0] ix,
  output op_class_e  cls,
  output logic       alt
);

  // Classify the byte; the stop byte takes priority over the group field
  always_comb begin
    cls = CLS_NOP;
    alt = ix[0];
    if (ix == STOP_BYTE) begin
      cls = CLS_STOP;
    end else begin
      case (ix[3:1])
        GRP_PTR:    cls = CLS_PTR;
        GRP_DATA:   cls = CLS_DATA;
        GRP_IO:     cls = CLS_IO;
        GRP_BRANCH: cls = CLS_BRANCH;
        default:    cls = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/bfx_control.sv
// bfx_control: multi-cycle fetch/execute sequencer for the bfX core.
// Optional feature: define BFX_RETIRE_CNT_EN to add the retire_cnt output.
// The data read strobe is raised in EXEC so the cell value is already on
// dmem_rdata in RD, letting RD register write data and output bytes directly.
module bfx_control
  import bfx_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int DP_W    = 15,
  parameter int DEPTH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  output logic [DP_W-1:0] dmem_addr,
  output logic            dmem_re,
  input  logic [7:0]      dmem_rdata,
  output logic            dmem_we,
  output logic [7:0]      dmem_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            halted,
`ifdef BFX_RETIRE_CNT_EN
  output logic [31:0]     retire_cnt,
`endif
  output logic            error
);

  localparam logic [PC_W-1:0]    PC_MAX    = {PC_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DP_W-1:0]    dp_q, dp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               scan_fwd_q, scan_fwd_d;
  op_class_e          op_cls_q, op_cls_d;
  logic               op_alt_q, op_alt_d;
  logic               dmem_we_q, dmem_we_d;
  logic [7:0]         dmem_wdata_q, dmem_wdata_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               halted_q, halted_d;
  logic               error_q, error_d;
  logic [DEPTH_W-1:0] scan_depth;

  op_class_e dec_cls;
  logic      dec_alt;

  bfx_decode u_decode (
    .ix  (imem_rdata),
    .cls (dec_cls),
    .alt (dec_alt)
  );

  assign imem_addr  = pc_q;
  assign dmem_addr  = dp_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wdata = dmem_wdata_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign in_ready   = in_ready_q;
  assign halted     = halted_q;
  assign error      = error_q;

  // Read strobe for every instruction that needs the current cell
  always_comb begin
    dmem_re = 1'b0;
    if (state_q == EXEC) begin
      dmem_re = (dec_cls == CLS_DATA) || (dec_cls == CLS_BRANCH) ||
                ((dec_cls == CLS_IO) && !dec_alt);
    end
  end

  // Next-state, pointer and registered-output computation for the sequencer
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dp_d         = dp_q;
    depth_d      = depth_q;
    scan_fwd_d   = scan_fwd_q;
    op_cls_d     = op_cls_q;
    op_alt_d     = op_alt_q;
    dmem_we_d    = 1'b0;
    dmem_wdata_d = dmem_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    in_ready_d   = in_ready_q;
    halted_d     = halted_q;
    error_d      = error_q;
    scan_depth   = depth_q;

    case (state_q)
      FETCH: state_d = EXEC;

      EXEC: begin
        op_cls_d = dec_cls;
        op_alt_d = dec_alt;
        case (dec_cls)
          CLS_PTR: begin
            dp_d    = dec_alt ? dp_q - DP_W'(1) : dp_q + DP_W'(1);
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end
          CLS_DATA:   state_d = RD;
          CLS_BRANCH: state_d = RD;
          CLS_IO: begin
            if (dec_alt) begin
              in_ready_d = 1'b1;
              state_d    = IN_WAIT;
            end else begin
              state_d = RD;
            end
          end
          CLS_STOP: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end
        endcase
      end

      RD: begin
        case (op_cls_q)
          CLS_DATA: begin
            dmem_wdata_d = op_alt_q ? dmem_rdata - 8'd1 : dmem_rdata + 8'd1;
            dmem_we_d    = 1'b1;
            state_d      = WR;
          end
          CLS_IO: begin
            out_data_d  = dmem_rdata;
            out_valid_d = 1'b1;
            state_d     = OUT_WAIT;
          end
          CLS_BRANCH: begin
            if (!op_alt_q && (dmem_rdata == 8'd0)) begin
              if (pc_q == PC_MAX) begin
                halted_d = 1'b1;
                error_d  = 1'b1;
                state_d  = HALT;
              end else begin
                depth_d    = DEPTH_W'(1);
                scan_fwd_d = 1'b1;
                pc_d       = pc_q + PC_W'(1);
                state_d    = SCAN_F;
              end
            end else if (op_alt_q && (dmem_rdata != 8'd0)) begin
              if (pc_q == '0) begin
                halted_d = 1'b1;
                error_d  = 1'b1;
                state_d  = HALT;
              end else begin
                depth_d    = DEPTH_W'(1);
                scan_fwd_d = 1'b0;
                pc_d       = pc_q - PC_W'(1);
                state_d    = SCAN_F;
              end
            end else begin
              pc_d    = pc_q + PC_W'(1);
              state_d = FETCH;
            end
          end
          default: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end
        endcase
      end

      WR: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = FETCH;
      end

      OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_q + PC_W'(1);
          state_d     = FETCH;
        end
      end

      IN_WAIT: begin
        if (in_valid) begin
          in_ready_d   = 1'b0;
          dmem_we_d    = 1'b1;
          dmem_wdata_d = in_data;
          pc_d         = pc_q + PC_W'(1);
          state_d      = FETCH;
        end
      end

      SCAN_F: state_d = SCAN_C;

      SCAN_C: begin
        if ((dec_cls == CLS_BRANCH) && (dec_alt != scan_fwd_q)) begin
          scan_depth = depth_q + DEPTH_W'(1);
        end else if ((dec_cls == CLS_BRANCH) && (dec_alt == scan_fwd_q)) begin
          scan_depth = depth_q - DEPTH_W'(1);
        end
        if ((dec_cls == CLS_BRANCH) && (dec_alt != scan_fwd_q) &&
            (depth_q == DEPTH_MAX)) begin
          halted_d = 1'b1;
          error_d  = 1'b1;
          state_d  = HALT;
        end else if (scan_depth == '0) begin
          depth_d = '0;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end else if ((scan_fwd_q && (pc_q == PC_MAX)) ||
                     (!scan_fwd_q && (pc_q == '0))) begin
          depth_d  = scan_depth;
          halted_d = 1'b1;
          error_d  = 1'b1;
          state_d  = HALT;
        end else begin
          depth_d = scan_depth;
          pc_d    = scan_fwd_q ? pc_q + PC_W'(1) : pc_q - PC_W'(1);
          state_d = SCAN_F;
        end
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  // Sequencer state, pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      dp_q         <= '0;
      depth_q      <= '0;
      scan_fwd_q   <= 1'b0;
      op_cls_q     <= CLS_NOP;
      op_alt_q     <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_wdata_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dp_q         <= dp_d;
      depth_q      <= depth_d;
      scan_fwd_q   <= scan_fwd_d;
      op_cls_q     <= op_cls_d;
      op_alt_q     <= op_alt_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wdata_q <= dmem_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
    end
  end

`ifdef BFX_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        retire_evt;

  // A non-NOP instruction retires when control returns to FETCH; stop retires entering HALT
  always_comb begin
    retire_evt = 1'b0;
    if ((state_q != FETCH) && (state_d == FETCH) &&
        !((state_q == EXEC) && (dec_cls == CLS_NOP))) begin
      retire_evt = 1'b1;
    end
    if ((state_q == EXEC) && (dec_cls == CLS_STOP)) begin
      retire_evt = 1'b1;
    end
    retire_cnt_d = retire_evt ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_bfx_control.sv
// Directed testbench for bfx_control with behavioural instruction ROM and data RAM.
module tb_bfx_control;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic [14:0] dmem_addr;
  logic        dmem_re;
  logic [7:0]  dmem_rdata;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        halted;
  logic        error;
`ifdef BFX_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [0:65535];
  logic [7:0] ram [0:32767];

  int          outCount  = 0;
  logic [7:0]  lastOut   = 8'h00;
  int          weCount   = 0;
  int          backScans = 0;
  logic [15:0] prevAddr  = 16'h0000;

  bfx_control dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .halted     (halted),
`ifdef BFX_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .error      (error)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM and RAM with one-cycle read latency
  always @(posedge clk) begin
    imem_rdata <= rom[imem_addr];
    if (dmem_re) dmem_rdata <= ram[dmem_addr];
    if (dmem_we) ram[dmem_addr] <= dmem_wdata;
  end

  // Monitor for output transfers, writes and backward scans started at a ']'
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        outCount = outCount + 1;
        lastOut  = out_data;
      end
      if (dmem_we) weCount = weCount + 1;
      if ((imem_addr < prevAddr) && (rom[prevAddr] == 8'h09)) backScans = backScans + 1;
    end
    prevAddr = imem_addr;
  end

  // Global watchdog
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clear memories, load a program and hold the core in reset for two cycles
  task automatic loadProgram(input logic [7:0] prog [], input logic [7:0] cell0);
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) rom[i] = 8'hFF;
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    ram[0] = cell0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run until the core halts or the cycle budget expires
  task automatic applyStimulus(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!halted && (n < maxCycles)) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    logic [7:0] prog [];
    int outBase;
    int weBase;
    int scanBase;
    int n;

    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;

    // Reset state
    prog = '{8'h06};
    loadProgram(prog, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_strobes", {30'd0, dmem_we, dmem_re}, 32'd0);
    checkOutput("rst_pc", {16'd0, imem_addr}, 32'd0);
    checkOutput("rst_dp", {17'd0, dmem_addr}, 32'd0);
    rst = 1'b0;

    // "+++." then stop: one output byte of 3
    $display("[TB] program +++.");
    outBase = outCount;
    prog = '{8'h02, 8'h02, 8'h02, 8'h04, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("p1", 200);
    checkOutput("p1_out_count", outCount - outBase, 1);
    checkOutput("p1_out_byte", {24'd0, lastOut}, 32'h03);
    checkOutput("p1_cell", {24'd0, ram[0]}, 32'h03);
    checkOutput("p1_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    checkOutput("p1_halt_strobes", {28'd0, dmem_we, dmem_re, out_valid, in_ready}, 32'd0);

    // Reset while waiting on output handshake
    $display("[TB] reset during OUT_WAIT");
    out_ready = 1'b0;
    prog = '{8'h02, 8'h04, 8'hFF};
    loadProgram(prog, 8'h00);
    n = 0;
    while (!out_valid && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ow_valid", {31'd0, out_valid}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("ow_hold_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("ow_hold_data", {24'd0, out_data}, 32'h01);
    rst = 1'b1;
    #1;
    checkOutput("ow_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ow_rst_pc", {16'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ow_after_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ow_after_pc", {16'd0, imem_addr}, 32'd0);
    out_ready = 1'b1;

    // Pointer and cell wrap: "<-" then stop
    $display("[TB] pointer and cell wrap");
    prog = '{8'h01, 8'h03, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("wrap", 100);
    checkOutput("wrap_dp", {17'd0, dmem_addr}, 32'h7FFF);
    checkOutput("wrap_cell", {24'd0, ram[32767]}, 32'hFF);

    // Loop "++[-]" then stop
    $display("[TB] loop ++[-]");
    weBase   = weCount;
    scanBase = backScans;
    prog = '{8'h02, 8'h02, 8'h08, 8'h03, 8'h09, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("loop", 300);
    checkOutput("loop_cell", {24'd0, ram[0]}, 32'h00);
    checkOutput("loop_back_scans", backScans - scanBase, 1);
    checkOutput("loop_writes", weCount - weBase, 4);
    checkOutput("loop_error", {31'd0, error}, 32'd0);

    // Skip "[++]" then stop with a zero cell
    $display("[TB] forward skip [++]");
    weBase = weCount;
    prog = '{8'h08, 8'h02, 8'h02, 8'h09, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("skip", 200);
    checkOutput("skip_writes", weCount - weBase, 0);
    checkOutput("skip_cell", {24'd0, ram[0]}, 32'h00);
    checkOutput("skip_error", {31'd0, error}, 32'd0);

    // Unmatched ']' at PC 0 with nonzero cell
    $display("[TB] unmatched ] at PC 0");
    prog = '{8'h09};
    loadProgram(prog, 8'h01);
    applyStimulus("unm0", 50);
    checkOutput("unm0_error", {31'd0, error}, 32'd1);

    // Unmatched ']' found by a backward scan reaching PC 0
    $display("[TB] unmatched ] after backward scan");
    prog = '{8'h02, 8'h09, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("unm1", 100);
    checkOutput("unm1_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    checkOutput("unm1_strobes", {30'd0, dmem_we, dmem_re}, 32'd0);

    // "+,." then stop with host input 8'h41
    $display("[TB] input then echo");
    outBase  = outCount;
    in_valid = 1'b1;
    in_data  = 8'h41;
    prog = '{8'h02, 8'h05, 8'h04, 8'hFF};
    loadProgram(prog, 8'h00);
    applyStimulus("io", 200);
    in_valid = 1'b0;
    checkOutput("io_cell", {24'd0, ram[0]}, 32'h41);
    checkOutput("io_out_count", outCount - outBase, 1);
    checkOutput("io_out_byte", {24'd0, lastOut}, 32'h41);
`ifdef BFX_RETIRE_CNT_EN
    checkOutput("io_retire_cnt", retire_cnt, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
